// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two requester handshakes and the shared external memory bus.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  // Port 0: cpu data-memory stage
  logic              req0;
  logic              wr_rd0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;

  // Port 1: loader/debug port
  logic              req1;
  logic              wr_rd1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;

  // Shared external memory bus
  logic              cs;
  logic              wr_rd;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_BUS_WRITE;
  logic [DATA_W-1:0] Data_BUS_READ;

  // Arbiter side
  modport master (
    input  req0, wr_rd0, addr0, wdata0,
    input  req1, wr_rd1, addr1, wdata1,
    input  Data_BUS_READ,
    output gnt0, done0, rdata0,
    output gnt1, done1, rdata1,
    output cs, wr_rd, ADDR, Data_BUS_WRITE
  );

  // Requester / memory side
  modport slave (
    output req0, wr_rd0, addr0, wdata0,
    output req1, wr_rd1, addr1, wdata1,
    output Data_BUS_READ,
    input  gnt0, done0, rdata0,
    input  gnt1, done1, rdata1,
    input  cs, wr_rd, ADDR, Data_BUS_WRITE
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter and fixed-length sequencer for the external memory bus.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               reset,
  mem_bus_arbiter_if.master  bus
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              cs_q, cs_d;
  logic              wr_rd_q, wr_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              pick;

  // Next-state and next-output decode; every register holds unless the state says otherwise.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cs_d     = cs_q;
    wr_rd_d  = wr_rd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    done0_d  = done0_q;
    done1_d  = done1_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    pick     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the port that did not own the bus last wins
          pick    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          owner_d = pick;
          cs_d    = 1'b1;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ACCESS;
          if (pick) begin
            wr_rd_d = bus.wr_rd1;
            addr_d  = bus.addr1;
            wdata_d = bus.wdata1;
            gnt1_d  = 1'b1;
          end else begin
            wr_rd_d = bus.wr_rd0;
            addr_d  = bus.addr0;
            wdata_d = bus.wdata0;
            gnt0_d  = 1'b1;
          end
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          cs_d    = 1'b0;
          state_d = DONE;
          if (owner_q) begin
            done1_d = 1'b1;
            if (!wr_rd_q) rdata1_d = bus.Data_BUS_READ;
          end else begin
            done0_d = 1'b1;
            if (!wr_rd_q) rdata0_d = bus.Data_BUS_READ;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        done0_d = 1'b0;
        done1_d = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        last_d  = owner_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cs_q     <= 1'b0;
      wr_rd_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cs_q     <= cs_d;
      wr_rd_q  <= wr_rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.cs             = cs_q;
  assign bus.wr_rd          = wr_rd_q;
  assign bus.ADDR           = addr_q;
  assign bus.Data_BUS_WRITE = wdata_q;
  assign bus.gnt0           = gnt0_q;
  assign bus.gnt1           = gnt1_q;
  assign bus.done0          = done0_q;
  assign bus.done1          = done1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized round-robin traffic.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned WC = 2;

  logic CLK   = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  // Transaction-level reference state
  int          last_owner;
  logic [31:0] exp_rdata [2];

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus   ();
  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_z ();

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut_z (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus_z)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 1) begin
      bus.req1 = r; bus.wr_rd1 = w; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = r; bus.wr_rd0 = w; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 1) ? bus.gnt1 : bus.gnt0;
  endfunction

  function automatic logic done_of(input int p);
    return (p == 1) ? bus.done1 : bus.done0;
  endfunction

  function automatic logic [31:0] rdata_of(input int p);
    return (p == 1) ? bus.rdata1 : bus.rdata0;
  endfunction

  task automatic model_reset();
    last_owner   = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  // Follows one complete access by port p; returns at the sample point of the done cycle.
  task automatic check_access(input int p, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rv, input int exp_wait);
    int waited = 0;
    int o = 1 - p;
    while (bus.cs !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("grant_latency", 32'(waited), 32'(exp_wait));
    for (int i = 0; i <= int'(WC); i++) begin
      chk("cs_high", 32'(bus.cs), 32'(1));
      chk("bus_addr", bus.ADDR, a);
      chk("bus_wr_rd", 32'(bus.wr_rd), 32'(wr));
      if (wr) chk("bus_wdata", bus.Data_BUS_WRITE, wd);
      chk("owner_gnt", 32'(gnt_of(p)), 32'(1));
      chk("other_gnt", 32'(gnt_of(o)), 32'(0));
      chk("owner_done_early", 32'(done_of(p)), 32'(0));
      chk("other_done", 32'(done_of(o)), 32'(0));
      // Only the value presented on the last cs cycle may be captured
      bus.Data_BUS_READ = (i == int'(WC)) ? rv : $urandom;
      // Owner's request inputs are ignored once granted
      set_req(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      tick();
    end
    if (!wr) exp_rdata[p] = rv;
    last_owner = p;
    chk("cs_low_in_done", 32'(bus.cs), 32'(0));
    chk("owner_done", 32'(done_of(p)), 32'(1));
    chk("owner_gnt_in_done", 32'(gnt_of(p)), 32'(1));
    chk("other_done_in_done", 32'(done_of(o)), 32'(0));
    chk("other_gnt_in_done", 32'(gnt_of(o)), 32'(0));
    chk("owner_rdata", rdata_of(p), exp_rdata[p]);
    chk("other_rdata", rdata_of(o), exp_rdata[o]);
    chk("addr_hold", bus.ADDR, a);
  endtask

  // Advances into the turnaround cycle and checks everything is released.
  task automatic idle_check();
    tick();
    chk("idle_cs", 32'(bus.cs), 32'(0));
    chk("idle_gnt0", 32'(bus.gnt0), 32'(0));
    chk("idle_gnt1", 32'(bus.gnt1), 32'(0));
    chk("idle_done0", 32'(bus.done0), 32'(0));
    chk("idle_done1", 32'(bus.done1), 32'(0));
  endtask

  initial begin
    int          prev_done;
    int          p;
    logic        pend  [2];
    logic        f_wr  [2];
    logic [31:0] f_addr[2];
    logic [31:0] f_wd  [2];
    logic        w;

    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    bus.Data_BUS_READ = '0;
    bus_z.req0 = 1'b0; bus_z.wr_rd0 = 1'b0; bus_z.addr0 = '0; bus_z.wdata0 = '0;
    bus_z.req1 = 1'b0; bus_z.wr_rd1 = 1'b0; bus_z.addr1 = '0; bus_z.wdata1 = '0;
    bus_z.Data_BUS_READ = '0;
    model_reset();

    // Reset values
    repeat (3) tick();
    chk("rst_cs", 32'(bus.cs), 32'(0));
    chk("rst_wr_rd", 32'(bus.wr_rd), 32'(0));
    chk("rst_addr", bus.ADDR, 32'(0));
    chk("rst_wdata", bus.Data_BUS_WRITE, 32'(0));
    chk("rst_gnt0", 32'(bus.gnt0), 32'(0));
    chk("rst_gnt1", 32'(bus.gnt1), 32'(0));
    chk("rst_done0", 32'(bus.done0), 32'(0));
    chk("rst_done1", 32'(bus.done1), 32'(0));
    chk("rst_rdata0", bus.rdata0, 32'(0));
    chk("rst_rdata1", bus.rdata1, 32'(0));
    reset = 1'b0;

    // Single read on port 0
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
    check_access(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    set_req(0, 1'b0, 1'b0, '0, '0);
    idle_check();

    // Single write on port 1
    set_req(1, 1'b1, 1'b1, 32'h20, 32'h12345678);
    check_access(1, 1'b1, 32'h20, 32'h12345678, $urandom, 1);
    set_req(1, 1'b0, 1'b0, '0, '0);
    idle_check();
    chk("write_keeps_rdata1", bus.rdata1, 32'(0));

    // Contention right after reset: strict 0,1,0,1 alternation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("rst_clears_rdata0", bus.rdata0, 32'(0));
    prev_done = 0;
    for (int i = 0; i < 4; i++) begin
      f_wr[0] = 1'($urandom_range(0, 1)); f_addr[0] = $urandom; f_wd[0] = $urandom;
      f_wr[1] = 1'($urandom_range(0, 1)); f_addr[1] = $urandom; f_wd[1] = $urandom;
      set_req(0, 1'b1, f_wr[0], f_addr[0], f_wd[0]);
      set_req(1, 1'b1, f_wr[1], f_addr[1], f_wd[1]);
      p = i % 2;
      check_access(p, f_wr[p], f_addr[p], f_wd[p], $urandom, 1);
      if (i > 0) chk("done_spacing", 32'(cycle - prev_done), 32'(WC + 3));
      prev_done = cycle;
      if (i == 3) begin
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
      end
      idle_check();
    end

    // Late request from port 1 while port 0 is mid-access
    set_req(0, 1'b1, 1'b0, 32'h0000_0444, 32'h0);
    tick();
    set_req(1, 1'b1, 1'b0, 32'h0000_0888, 32'h0);
    check_access(0, 1'b0, 32'h0000_0444, 32'h0, 32'h5A5A_1234, 0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, 32'h0000_0888, 32'h0);
    idle_check();
    check_access(1, 1'b0, 32'h0000_0888, 32'h0, 32'h0F0F_5678, 1);
    set_req(1, 1'b0, 1'b0, '0, '0);
    idle_check();

    // Reset on the second cs cycle of a read aborts it cleanly
    set_req(0, 1'b1, 1'b0, 32'h300, 32'h0);
    tick();
    chk("abort_cs_first", 32'(bus.cs), 32'(1));
    tick();
    chk("abort_cs_second", 32'(bus.cs), 32'(1));
    reset = 1'b1;
    bus.Data_BUS_READ = 32'hCAFEF00D;
    set_req(0, 1'b0, 1'b0, '0, '0);
    tick();
    reset = 1'b0;
    model_reset();
    chk("abort_cs", 32'(bus.cs), 32'(0));
    chk("abort_gnt0", 32'(bus.gnt0), 32'(0));
    chk("abort_done0", 32'(bus.done0), 32'(0));
    chk("abort_rdata0", bus.rdata0, 32'(0));
    chk("abort_rdata1", bus.rdata1, 32'(0));
    chk("abort_addr", bus.ADDR, 32'(0));
    tick();
    chk("abort_no_done0", 32'(bus.done0), 32'(0));
    chk("abort_stays_idle", 32'(bus.cs), 32'(0));
    set_req(0, 1'b1, 1'b0, 32'h304, 32'h0);
    check_access(0, 1'b0, 32'h304, 32'h0, 32'h7777_AAAA, 1);
    set_req(0, 1'b0, 1'b0, '0, '0);
    idle_check();

    // Zero-wait build: cs for one cycle, done on the second cycle
    bus_z.req0 = 1'b1; bus_z.wr_rd0 = 1'b0; bus_z.addr0 = 32'h44;
    bus_z.Data_BUS_READ = 32'h0BADF00D;
    tick();
    chk("z_cs", 32'(bus_z.cs), 32'(1));
    chk("z_gnt0", 32'(bus_z.gnt0), 32'(1));
    chk("z_addr", bus_z.ADDR, 32'h44);
    chk("z_done_early", 32'(bus_z.done0), 32'(0));
    bus_z.req0 = 1'b0;
    tick();
    chk("z_cs_low", 32'(bus_z.cs), 32'(0));
    chk("z_done0", 32'(bus_z.done0), 32'(1));
    chk("z_rdata0", bus_z.rdata0, 32'h0BADF00D);
    chk("z_gnt1", 32'(bus_z.gnt1), 32'(0));
    tick();
    chk("z_done_clear", 32'(bus_z.done0), 32'(0));
    chk("z_gnt_clear", 32'(bus_z.gnt0), 32'(0));

    // Randomized traffic against the round-robin reference
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int q = 0; q < 2; q++) begin
        if (!pend[q] && $urandom_range(0, 1) == 1) begin
          pend[q]   = 1'b1;
          f_wr[q]   = 1'($urandom_range(0, 1));
          f_addr[q] = $urandom;
          f_wd[q]   = $urandom;
        end
      end
      if (!pend[0] && !pend[1]) begin
        q_pick: begin
          p = $urandom_range(0, 1);
          pend[p]   = 1'b1;
          f_wr[p]   = 1'($urandom_range(0, 1));
          f_addr[p] = $urandom;
          f_wd[p]   = $urandom;
        end
      end
      for (int q = 0; q < 2; q++) begin
        if (pend[q]) set_req(q, 1'b1, f_wr[q], f_addr[q], f_wd[q]);
        else         set_req(q, 1'b0, 1'b0, $urandom, $urandom);
      end
      if (pend[0] && pend[1]) p = 1 - last_owner;
      else                    p = pend[1] ? 1 : 0;
      w = f_wr[p];
      check_access(p, w, f_addr[p], f_wd[p], $urandom, 1);
      pend[p] = 1'b0;
      for (int q = 0; q < 2; q++) begin
        if (pend[q]) set_req(q, 1'b1, f_wr[q], f_addr[q], f_wd[q]);
        else         set_req(q, 1'b0, 1'b0, $urandom, $urandom);
      end
      idle_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
